// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package imem_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int IMEM_DEPTH_DEF = 1024;
    localparam int IMEM_AW_DEF    = $clog2(IMEM_DEPTH_DEF);

    // Owner of the response that is due in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    // A byte address is word aligned when its two low bits are clear.
    function automatic logic word_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Combinational legality test for one requester: alignment and range,
// plus the word index used to address the memory.
module imem_addr_check
    import imem_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              legal_o,
    output logic [AW-1:0]     idx_o
);

    logic [ADDR_W-1:0] word_s;

    // Word index and legality: aligned and inside the memory.
    always_comb begin
        word_s  = {2'b00, addr_i[ADDR_W-1:2]};
        legal_o = word_aligned(addr_i) && (word_s < ADDR_W'(IMEM_DEPTH));
        idx_o   = word_s[AW-1:0];
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port instruction memory.
// The loader normally wins; a waiting fetch is forced through after
// STARVE_MAX consecutive loader grants. Responses follow one cycle later.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    localparam int AW        = $clog2(IMEM_DEPTH),
    localparam int CW        = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    // loader port
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,
    // memory port
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    logic          f_legal_s;
    logic          l_legal_s;
    logic [AW-1:0] f_idx_s;
    logic [AW-1:0] l_idx_s;
    logic          fetch_wins_s;

    logic [CW-1:0] starve_q, starve_d;
    owner_t        owner_q, owner_d;
    logic          err_q, err_d;
    logic          rd_q, rd_d;     // response returns memory data

    imem_addr_check #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .AW         (AW)
    ) u_f_check (
        .addr_i  (f_addr),
        .legal_o (f_legal_s),
        .idx_o   (f_idx_s)
    );

    imem_addr_check #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .AW         (AW)
    ) u_l_check (
        .addr_i  (l_addr),
        .legal_o (l_legal_s),
        .idx_o   (l_idx_s)
    );

    // Grant selection and memory command for the current cycle.
    always_comb begin
        f_gnt        = 1'b0;
        l_gnt        = 1'b0;
        m_en         = 1'b0;
        m_we         = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
        fetch_wins_s = f_req && (starve_q == CW'(STARVE_MAX));

        if (rst) begin
            f_gnt = 1'b0;
            l_gnt = 1'b0;
        end else if (f_req && (fetch_wins_s || !l_req)) begin
            f_gnt = 1'b1;
        end else if (l_req) begin
            l_gnt = 1'b1;
        end else begin
            f_gnt = 1'b0;
            l_gnt = 1'b0;
        end

        // Illegal accesses are granted but never reach the memory.
        if (f_gnt) begin
            m_en   = f_legal_s;
            m_addr = f_legal_s ? f_idx_s : '0;
        end else if (l_gnt) begin
            m_en    = l_legal_s;
            m_we    = l_legal_s & l_we;
            m_addr  = l_legal_s ? l_idx_s : '0;
            m_wdata = l_legal_s ? l_wdata : '0;
        end else begin
            m_en = 1'b0;
        end
    end

    // Starvation counter: counts loader grants taken while fetch waits.
    always_comb begin
        starve_d = starve_q;
        if (f_gnt || !f_req) begin
            starve_d = '0;
        end else if (l_gnt && (starve_q < CW'(STARVE_MAX))) begin
            starve_d = starve_q + CW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Response bookkeeping: who gets the answer next cycle and what kind.
    always_comb begin
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        rd_d    = 1'b0;
        if (f_gnt) begin
            owner_d = OWN_FETCH;
            err_d   = !f_legal_s;
            rd_d    = f_legal_s;
        end else if (l_gnt) begin
            owner_d = OWN_LOAD;
            err_d   = !l_legal_s;
            rd_d    = l_legal_s && !l_we;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // State registers with synchronous reset; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
        end
    end

    // Route the response to its owner; the other side sees zeros.
    always_comb begin
        f_rvalid = 1'b0;
        f_err    = 1'b0;
        f_rdata  = '0;
        l_rvalid = 1'b0;
        l_err    = 1'b0;
        l_rdata  = '0;
        if (rst) begin
            f_rvalid = 1'b0;
            l_rvalid = 1'b0;
        end else begin
            case (owner_q)
                OWN_FETCH: begin
                    f_rvalid = 1'b1;
                    f_err    = err_q;
                    f_rdata  = rd_q ? m_rdata : '0;
                end
                OWN_LOAD: begin
                    l_rvalid = 1'b1;
                    l_err    = err_q;
                    l_rdata  = rd_q ? m_rdata : '0;
                end
                default: begin
                    f_rvalid = 1'b0;
                    l_rvalid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed, table-driven bench for imem_arbiter with a behavioural memory.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, l_req, l_we;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        l_gnt, l_rvalid, l_err;
    logic [31:0] l_rdata;
    logic        m_en, m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.STARVE_MAX(4), .IMEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Memory model: unwritten word i reads as 0x10000000 + i.
    logic [31:0] mem [1024];
    logic        wr_flag [1024];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 1024; k++) wr_flag[k] <= 1'b0;
        end else if (m_en) begin
            if (m_we) begin
                mem[m_addr]     <= m_wdata;
                wr_flag[m_addr] <= 1'b1;
            end else begin
                m_rdata <= wr_flag[m_addr] ? mem[m_addr] : (32'h1000_0000 + {22'd0, m_addr});
            end
        end
    end

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic        e_fg, e_lg, e_men, e_mwe;
        logic [9:0]  e_maddr;
        logic [31:0] e_mwdata;
        logic        e_fv, e_fe;
        logic [31:0] e_frd;
        logic        e_lv, e_le;
        logic [31:0] e_lrd;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                         input logic lw, input logic [31:0] la, input logic [31:0] ld);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every output must be zero while reset is held.
    task automatic chk_all_zero(input string tag);
        chk({tag, " f_gnt"},    {31'd0, f_gnt},    32'd0);
        chk({tag, " l_gnt"},    {31'd0, l_gnt},    32'd0);
        chk({tag, " f_rvalid"}, {31'd0, f_rvalid}, 32'd0);
        chk({tag, " l_rvalid"}, {31'd0, l_rvalid}, 32'd0);
        chk({tag, " f_err"},    {31'd0, f_err},    32'd0);
        chk({tag, " l_err"},    {31'd0, l_err},    32'd0);
        chk({tag, " f_rdata"},  f_rdata,           32'd0);
        chk({tag, " l_rdata"},  l_rdata,           32'd0);
        chk({tag, " m_en"},     {31'd0, m_en},     32'd0);
        chk({tag, " m_we"},     {31'd0, m_we},     32'd0);
        chk({tag, " m_addr"},   {22'd0, m_addr},   32'd0);
        chk({tag, " m_wdata"},  m_wdata,           32'd0);
    endtask

    // Both ports request for n cycles; bit j of pat is 1 where fetch must win.
    task automatic contend(input string tag, input int n, input logic [15:0] pat);
        for (int j = 0; j < n; j++) begin
            drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("%s c%0d f_gnt", tag, j), {31'd0, f_gnt}, {31'd0, pat[j]});
            chk($sformatf("%s c%0d l_gnt", tag, j), {31'd0, l_gnt}, {31'd0, !pat[j]});
            next_cycle();
        end
    endtask

    initial begin
        //        f_req f_addr        l_req l_we  l_addr        l_wdata
        //        fg lg men mwe maddr mwdata  fv fe frd  lv le lrd
        tbl[0]  = '{1'b1, 32'h8,      1'b0, 1'b0, 32'h0,    32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 10'd2,    32'h0,
                    1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    32'h0,
                    1'b1, 1'b0, 32'h1000_0002,  1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h10,   32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b1, 1'b1, 10'd4,    32'hDEAD_BEEF,
                    1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h10,     1'b0, 1'b0, 32'h0,    32'h0,
                    1'b1, 1'b0, 1'b1, 1'b0, 10'd4,    32'h0,
                    1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 32'h6,      1'b0, 1'b0, 32'h0,    32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 10'd0,    32'h0,
                    1'b1, 1'b0, 32'hDEAD_BEEF,  1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'h1000,   1'b0, 1'b0, 32'h0,    32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 10'd0,    32'h0,
                    1'b1, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'hC,    32'h0,
                    1'b0, 1'b1, 1'b1, 1'b0, 10'd3,    32'h0,
                    1'b1, 1'b1, 32'h0,          1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,      1'b1, 1'b1, 32'hFFC,  32'h1234_5678,
                    1'b0, 1'b1, 1'b1, 1'b1, 10'd1023, 32'h1234_5678,
                    1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h1000_0003};
        tbl[8]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'h1002, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 10'd0,    32'h0,
                    1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,      1'b1, 1'b0, 32'hFFC,  32'h0,
                    1'b0, 1'b1, 1'b1, 1'b0, 10'd1023, 32'h0,
                    1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    32'h0,
                    1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h1234_5678};
        tbl[11] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 10'd0,    32'h0,
                    1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 32'h0};

        // Reset with both requests active: everything must stay quiet.
        rst = 1'b1;
        drive(1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();

        // Table of single-cycle vectors; response fields belong to the previous row.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].f_req, tbl[i].f_addr, tbl[i].l_req, tbl[i].l_we,
                  tbl[i].l_addr, tbl[i].l_wdata);
            @(negedge clk);
            chk($sformatf("v%0d f_gnt", i),    {31'd0, f_gnt},    {31'd0, tbl[i].e_fg});
            chk($sformatf("v%0d l_gnt", i),    {31'd0, l_gnt},    {31'd0, tbl[i].e_lg});
            chk($sformatf("v%0d m_en", i),     {31'd0, m_en},     {31'd0, tbl[i].e_men});
            chk($sformatf("v%0d m_we", i),     {31'd0, m_we},     {31'd0, tbl[i].e_mwe});
            chk($sformatf("v%0d m_addr", i),   {22'd0, m_addr},   {22'd0, tbl[i].e_maddr});
            chk($sformatf("v%0d m_wdata", i),  m_wdata,           tbl[i].e_mwdata);
            chk($sformatf("v%0d f_rvalid", i), {31'd0, f_rvalid}, {31'd0, tbl[i].e_fv});
            chk($sformatf("v%0d f_err", i),    {31'd0, f_err},    {31'd0, tbl[i].e_fe});
            chk($sformatf("v%0d f_rdata", i),  f_rdata,           tbl[i].e_frd);
            chk($sformatf("v%0d l_rvalid", i), {31'd0, l_rvalid}, {31'd0, tbl[i].e_lv});
            chk($sformatf("v%0d l_err", i),    {31'd0, l_err},    {31'd0, tbl[i].e_le});
            chk($sformatf("v%0d l_rdata", i),  l_rdata,           tbl[i].e_lrd);
            next_cycle();
        end

        // Continuous contention: L,L,L,L,F repeating.
        contend("starve", 10, 16'b0000_0010_0001_0000);

        // Dropping f_req clears the counter, so a full run of four L follows.
        contend("pre", 2, 16'h0000);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("fidle l_gnt", {31'd0, l_gnt}, 32'd1);
        next_cycle();
        contend("clr", 5, 16'b0000_0000_0001_0000);

        // Reset right after a fetch grant drops the pending response.
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstdrop f_gnt", {31'd0, f_gnt}, 32'd1);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_all_zero("rstmid");
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstdrop f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rstdrop l_rvalid", {31'd0, l_rvalid}, 32'd0);
        next_cycle();

        // Counter part-way through a run must restart from zero after reset.
        contend("part", 2, 16'h0000);
        rst = 1'b1;
        drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst = 1'b0;
        contend("restart", 5, 16'b0000_0000_0001_0000);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive loader grants while fetch waits.
REQ-002 SHALL have parameter IMEM_DEPTH, default 1024: words in the instruction memory.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port f_req  input  1  fetch read request, held until granted.
REQ-006 SHALL have port f_addr  input  32  fetch byte address.
REQ-007 SHALL have port f_gnt  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port f_rvalid  output  1  fetch response valid.
REQ-009 SHALL have port f_rdata  output  32  fetched instruction word.
REQ-010 SHALL have port f_err  output  1  fetch access rejected (misaligned/out of range); qualified by f_rvalid.
REQ-011 SHALL have port l_req  input  1  loader request, held until granted.
REQ-012 SHALL have port l_we  input  1  loader write (1) / read (0).
REQ-013 SHALL have port l_addr  input  32  loader byte address.
REQ-014 SHALL have port l_wdata  input  32  loader write word.
REQ-015 SHALL have port l_gnt, l_rvalid, l_err  output  1 each  loader equivalents of f_gnt/f_rvalid/f_err.
REQ-016 SHALL have port l_rdata  output  32  loader read data; 0 for writes.
REQ-017 SHALL have port m_en  output  1  memory access enable.
REQ-018 SHALL have port m_we  output  1  memory write enable.
REQ-019 SHALL have port m_addr  output  $clog2(IMEM_DEPTH)  word index (byte address / 4).
REQ-020 SHALL have port m_wdata  output  32  memory write data.
REQ-021 SHALL have port m_rdata  input  32  memory read data, valid one cycle after m_en with m_we=0.

Function
REQ-022 Grant SHALL be combinational in the request cycle; at most one of f_gnt/l_gnt per cycle.
REQ-023 Priority: loader wins by default; fetch wins when f_req is pending and starve counter == STARVE_MAX.
REQ-024 Starve counter SHALL increment on each l_gnt while f_req is high and clear on f_gnt or when f_req is low; saturates at STARVE_MAX.
REQ-025 Access legal iff addr[1:0]==0 and addr/4 < IMEM_DEPTH; legal grant drives m_en=1, m_addr=addr[..:2], m_we=l_we&l_gnt, m_wdata=l_wdata.
REQ-026 Illegal access SHALL still be granted but m_en=0; response carries err=1, rdata=0.
REQ-027 Response latency exactly 1 cycle: rvalid of the granted requester pulses one cycle after gnt; owner held in a response register (NONE/FETCH/LOAD).
REQ-028 Read response: rdata=m_rdata; write response: rvalid pulses as ack, rdata=0, err=0 when legal.
REQ-029 Back-to-back grants SHALL be allowed every cycle (full throughput, no bubble).
REQ-030 Idle cycle (no req): m_en=0, no gnt, response register loads NONE.
REQ-031 rdata/err of a non-owning requester SHALL be 0.

Reset
REQ-032 While rst=1: all gnt, rvalid, err, m_en, m_we = 0; rdata, m_addr, m_wdata = 0; requests ignored.
REQ-033 rst SHALL clear starve counter to 0 and response owner to NONE; an in-flight response is dropped (no rvalid after reset).

Structure
REQ-034 Package imem_pkg SHALL hold IMEM_DEPTH default, address width constant, and typedef enum owner_t {OWN_NONE, OWN_FETCH, OWN_LOAD}.
REQ-035 Sub-module imem_addr_check (combinational legality test, used once per requester) SHALL be instantiated twice.

Verification
REQ-036 f_req, f_addr=0x8 alone -> f_gnt same cycle, m_addr=2, m_en=1; next cycle f_rvalid=1, f_rdata=m_rdata.
REQ-037 l_req write l_addr=0x10, l_wdata=0xDEADBEEF, then fetch 0x10 -> m_we=1 at index 4; fetch returns 0xDEADBEEF.
REQ-038 l_req and f_req both high continuously -> grants L,L,L,L,F repeating (STARVE_MAX=4).
REQ-039 f_addr=0x6, then f_addr=0x1000 -> each granted, m_en=0, f_rvalid=1 with f_err=1, f_rdata=0.
REQ-040 Assert rst in cycle after a fetch grant -> no f_rvalid follows; all outputs 0 during rst; counter restarts at 0.
